// File: rtl/uart_pkg.sv
// Shared UART receiver types and frame constants.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;
  localparam int unsigned BIT_IDX_W = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } uart_rx_state_t;

  // Counter value at the middle of the start bit.
  function automatic int unsigned half_bit(input int unsigned clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Metastability filter; reset loads the line's idle level.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, frame error strobe, registered outputs.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 213
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_serial,
  output logic       rx_dv,
  output logic [7:0] rx_byte,
  output logic       rx_frame_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(half_bit(CLKS_PER_BIT));
  localparam logic [BIT_IDX_W-1:0] IDX_LAST = BIT_IDX_W'(DATA_BITS - 1);

  logic rx_s;

  uart_rx_state_t        state_q, state_d;
  logic [CNT_W-1:0]      clk_cnt_q, clk_cnt_d;
  logic [BIT_IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [7:0]            rx_byte_q, rx_byte_d;
  logic                  rx_dv_q, rx_dv_d;
  logic                  rx_frame_err_q, rx_frame_err_d;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_serial),
    .q     (rx_s)
  );

  // Next-state, sampling and strobe logic; strobes default low every cycle.
  always_comb begin
    state_d        = state_q;
    clk_cnt_d      = clk_cnt_q;
    bit_idx_d      = bit_idx_q;
    shift_d        = shift_q;
    rx_byte_d      = rx_byte_q;
    rx_dv_d        = 1'b0;
    rx_frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        if (!rx_s) begin
          state_d = START;
        end
      end

      START: begin
        if (clk_cnt_q == CNT_HALF) begin
          clk_cnt_d = '0;
          // A line that is high again at mid start bit was only a glitch.
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == IDX_LAST) begin
            bit_idx_d = '0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          state_d   = CLEANUP;
          if (rx_s) begin
            rx_dv_d   = 1'b1;
            rx_byte_d = shift_q;
          end else begin
            rx_frame_err_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      CLEANUP: begin
        clk_cnt_d = '0;
        state_d   = IDLE;
      end

      default: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  // State and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      clk_cnt_q      <= '0;
      bit_idx_q      <= '0;
      shift_q        <= '0;
      rx_byte_q      <= 8'h00;
      rx_dv_q        <= 1'b0;
      rx_frame_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      clk_cnt_q      <= clk_cnt_d;
      bit_idx_q      <= bit_idx_d;
      shift_q        <= shift_d;
      rx_byte_q      <= rx_byte_d;
      rx_dv_q        <= rx_dv_d;
      rx_frame_err_q <= rx_frame_err_d;
    end
  end

  assign rx_dv        = rx_dv_q;
  assign rx_byte      = rx_byte_q;
  assign rx_frame_err = rx_frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: byte-level expected-event queue vs. DUT strobes.
module tb_uart_rx;

  localparam int unsigned CPB = 213;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_serial;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       rx_frame_err;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] last_good;
  int         total = 0;
  int         bad   = 0;

  uart_rx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_serial    (rx_serial),
    .rx_dv        (rx_dv),
    .rx_byte      (rx_byte),
    .rx_frame_err (rx_frame_err)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe cycle consumes one expected event.
  always @(negedge clk) begin
    if (!reset && (rx_dv || rx_frame_err)) begin
      check("strobe_exclusive", {31'b0, rx_dv & rx_frame_err}, 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: dv=%0b ferr=%0b byte=0x%02h, none expected at %0t",
                 rx_dv, rx_frame_err, rx_byte, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_kind_ferr", {31'b0, rx_frame_err}, {31'b0, mon_e.is_err});
        check("strobe_byte", 32'(rx_byte), 32'(mon_e.data));
      end
    end
  end

  task automatic drive_bit(input logic v);
    rx_serial = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int unsigned n);
    rx_serial = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Reference: a good stop yields the byte; a bad stop repeats the last good byte.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    exp_t e;
    e.is_err = !stop_ok;
    if (stop_ok) last_good = b;
    e.data = last_good;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 30 * CPB) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    logic       ok;
    int unsigned gap;
    logic [7:0] abort_byte;

    reset     = 1'b1;
    rx_serial = 1'b1;
    last_good = 8'h00;
    repeat (5) @(negedge clk);
    check("reset_rx_byte", 32'(rx_byte), 32'h00);
    check("reset_rx_dv", {31'b0, rx_dv}, 32'd0);
    check("reset_rx_frame_err", {31'b0, rx_frame_err}, 32'd0);
    reset = 1'b0;

    // Long idle line: nothing may happen.
    idle(10000);
    check("idle_rx_byte", 32'(rx_byte), 32'h00);
    check("idle_no_events", exp_q.size(), 32'd0);

    send_frame(8'h55, 1'b1);
    idle(CPB);
    wait_drain("drain_55");
    check("byte_55", 32'(rx_byte), 32'h55);

    // Back-to-back frames, no idle gap.
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(CPB);
    wait_drain("drain_a5_3c");
    check("byte_3c", 32'(rx_byte), 32'h3C);

    // Short low glitch must be rejected.
    rx_serial = 1'b0;
    repeat (50) @(negedge clk);
    idle(3 * CPB);
    check("glitch_rx_byte", 32'(rx_byte), 32'(last_good));

    // Stop bit low -> frame error, byte held.
    send_frame(8'hF0, 1'b0);
    idle(2 * CPB);
    wait_drain("drain_f0");
    check("ferr_rx_byte_held", 32'(rx_byte), 32'(last_good));

    // Reset in the middle of bit 3 aborts the frame.
    abort_byte = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(abort_byte[i]);
    rx_serial = abort_byte[3];
    repeat (100) @(negedge clk);
    reset     = 1'b1;
    rx_serial = 1'b1;
    repeat (15) @(negedge clk);
    check("midreset_rx_dv", {31'b0, rx_dv}, 32'd0);
    reset     = 1'b0;
    last_good = 8'h00;
    idle(3 * CPB);
    check("after_abort_rx_byte", 32'(rx_byte), 32'h00);
    send_frame(8'h81, 1'b1);
    idle(CPB);
    wait_drain("drain_81");
    check("byte_81", 32'(rx_byte), 32'h81);

    // Randomized frames with random stop validity, gaps and glitches.
    for (int f = 0; f < 12; f++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      send_frame(b, ok);
      gap = ok ? $urandom_range(0, 2) : $urandom_range(1, 2);
      if (ok && gap == 2 && $urandom_range(0, 1) == 1) begin
        rx_serial = 1'b0;
        repeat ($urandom_range(1, 80)) @(negedge clk);
        rx_serial = 1'b1;
      end
      // Finish the gap on a bit boundary measured from the stop bit end.
      idle(gap * CPB);
    end
    idle(2 * CPB);
    wait_drain("drain_random");
    check("final_rx_byte", 32'(rx_byte), 32'(last_good));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
